// File: rtl/move_issuer.sv
// Player-side move front end: debounces buttons, steers a column cursor and
// hands drops to the column-height counter through a one-cycle add strobe.
module move_issuer #(
  parameter int NUM_COLS        = 4,
  parameter int HW              = 3,
  parameter int MAX_HEIGHT      = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_drop,
  input  logic [NUM_COLS*HW-1:0]       count,
  output logic [NUM_COLS-1:0]          column,
  output logic                         add,
  output logic [$clog2(NUM_COLS)-1:0]  cursor,
  output logic                         player,
  output logic                         busy,
  output logic                         move_done,
  output logic                         full_err,
  output logic                         ack_err
);

  localparam int CW  = $clog2(NUM_COLS);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [HW-1:0]  MAX_H    = HW'(MAX_HEIGHT);
  localparam logic [CW-1:0]  LAST_COL = CW'(NUM_COLS - 1);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, REJECT} state_t;

  // bit 0 = left, bit 1 = right, bit 2 = drop
  logic [2:0]     raw, sync1, sync2, level, evt;
  logic [DBW-1:0] db_cnt [3];

  state_t         state;
  logic [HW-1:0]  h0;
  logic [HW-1:0]  slice;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  cursor_nxt;

  assign raw   = {btn_drop, btn_right, btn_left};
  assign slice = count[HW*cursor +: HW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level flips only after a full run of disagreeing samples; evt marks a rising flip.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      evt   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        evt[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          evt[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    cursor_nxt = cursor;
    if (state == IDLE && !evt[2] && (evt[0] ^ evt[1])) begin
      if (evt[0])
        cursor_nxt = (cursor == '0) ? LAST_COL : cursor - CW'(1);
      else
        cursor_nxt = (cursor == LAST_COL) ? '0 : cursor + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cursor    <= '0;
      column    <= ~NUM_COLS'(1);
      add       <= 1'b0;
      player    <= 1'b0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      full_err  <= 1'b0;
      ack_err   <= 1'b0;
      h0        <= '0;
      timer     <= '0;
    end else begin
      add       <= 1'b0;
      move_done <= 1'b0;
      full_err  <= 1'b0;
      ack_err   <= 1'b0;
      cursor    <= cursor_nxt;
      column    <= ~(NUM_COLS'(1) << cursor_nxt);
      case (state)
        IDLE: begin
          if (evt[2]) begin
            state <= CHECK;
            busy  <= 1'b1;
          end
        end
        CHECK: begin
          h0 <= slice;
          if (slice >= MAX_H) begin
            state <= REJECT;
          end else begin
            state <= ISSUE;
            add   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
          timer <= '0;
        end
        WAIT_ACK: begin
          if (slice == h0 + HW'(1)) begin
            move_done <= 1'b1;
            player    <= ~player;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (timer == T_LAST) begin
            ack_err <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REJECT: begin
          full_err <= 1'b1;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_issuer.sv
// Directed bench for move_issuer: a small height-counter model answers add strobes
// and negedge monitors count pulses so each step can be checked against hand values.
module tb_move_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_drop = 1'b0;
  logic [11:0] count;
  logic [3:0]  column;
  logic        add;
  logic [1:0]  cursor;
  logic        player, busy, move_done, full_err, ack_err;

  logic [2:0]  heights [4];
  logic        inc_en = 1'b0;
  logic        prev_add = 1'b0;
  logic [3:0]  col_at_add = 4'hf;
  int          vectors = 0;
  int          fails = 0;
  int          add_cnt = 0, md_cnt = 0, fe_cnt = 0, ae_cnt = 0, consec = 0;

  move_issuer dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .count(count), .column(column), .add(add), .cursor(cursor),
    .player(player), .busy(busy), .move_done(move_done),
    .full_err(full_err), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  assign count = {heights[3], heights[2], heights[1], heights[0]};

  // Counter model increments the column selected by the active-low one-hot code.
  always @(negedge clk) begin
    if (add) begin
      add_cnt++;
      col_at_add = column;
      if (prev_add) consec++;
      if (inc_en)
        for (int c = 0; c < 4; c++)
          if (!column[c]) heights[c] = heights[c] + 3'd1;
    end
    prev_add = add;
    if (move_done) md_cnt++;
    if (full_err)  fe_cnt++;
    if (ack_err)   ae_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic l, input logic r, input logic d);
    btn_left  = l;
    btn_right = r;
    btn_drop  = d;
    repeat (25) @(negedge clk);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < 4; c++) heights[c] = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check_output("rst_column", column, 4'b1110);
    check_output("rst_cursor", cursor, 2'd0);
    check_output("rst_player", player, 1'b0);
    check_output("rst_add", add, 1'b0);
    check_output("rst_busy", busy, 1'b0);

    apply_stimulus(0, 1, 0);
    check_output("right1_cursor", cursor, 2'd1);
    check_output("right1_column", column, 4'b1101);
    apply_stimulus(0, 1, 0);
    check_output("right2_cursor", cursor, 2'd2);
    apply_stimulus(0, 1, 0);
    check_output("right3_cursor", cursor, 2'd3);
    check_output("right3_column", column, 4'b0111);
    apply_stimulus(1, 0, 0);
    check_output("left1_cursor", cursor, 2'd2);
    apply_stimulus(0, 1, 0);
    check_output("right4_cursor", cursor, 2'd3);
    apply_stimulus(0, 1, 0);
    check_output("wrap_cursor", cursor, 2'd0);
    check_output("wrap_column", column, 4'b1110);

    // successful drop into column 1
    apply_stimulus(0, 1, 0);
    heights[1] = 3'd2;
    inc_en = 1'b1;
    apply_stimulus(0, 0, 1);
    check_output("drop_add_cnt", add_cnt, 1);
    check_output("drop_add_col", col_at_add, 4'b1101);
    check_output("drop_md_cnt", md_cnt, 1);
    check_output("drop_player", player, 1'b1);
    check_output("drop_height", count[5:3], 3'd3);
    check_output("drop_busy", busy, 1'b0);

    // full column 0
    apply_stimulus(1, 0, 0);
    check_output("full_cursor", cursor, 2'd0);
    heights[0] = 3'd6;
    apply_stimulus(0, 0, 1);
    check_output("full_add_cnt", add_cnt, 1);
    check_output("full_fe_cnt", fe_cnt, 1);
    check_output("full_player", player, 1'b1);

    // counter never acknowledges
    heights[0] = 3'd2;
    inc_en = 1'b0;
    apply_stimulus(0, 0, 1);
    check_output("ack_add_cnt", add_cnt, 2);
    check_output("ack_ae_cnt", ae_cnt, 1);
    check_output("ack_md_cnt", md_cnt, 1);
    check_output("ack_player", player, 1'b1);
    check_output("ack_height", count[2:0], 3'd2);

    // bounce shorter than the debounce window
    for (int k = 0; k < 3; k++) begin
      btn_right = 1'b1;
      repeat (5) @(negedge clk);
      btn_right = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    check_output("bounce_cursor", cursor, 2'd0);

    // reset while add is high
    heights[0] = 3'd1;
    btn_drop = 1'b1;
    for (int i = 0; i < 60 && !add; i++) @(negedge clk);
    check_output("issue_seen", add, 1'b1);
    #2;
    reset = 1'b0;
    btn_drop = 1'b0;
    #1;
    check_output("midrst_add", add, 1'b0);
    check_output("midrst_column", column, 4'b1110);
    check_output("midrst_cursor", cursor, 2'd0);
    check_output("midrst_player", player, 1'b0);
    check_output("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check_output("post_rst_adds", add_cnt, 3);

    apply_stimulus(1, 1, 0);
    check_output("both_cursor", cursor, 2'd0);
    check_output("both_column", column, 4'b1110);
    check_output("add_never_consec", consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
